fp_sgnj_dec_d: RTL and testbench

Decode/issue stage that feeds the double-precision sign-injection unit.
- Accepts RISC-V OP-FP instruction words together with their source-register values through a valid/ready handshake.
- Recognises FSGNJ.D, FSGNJN.D and FSGNJX.D, and produces the 2-bit op code, operands and rd for the sign-injection datapath.
- Registered output with a one-entry skid buffer, so throughput is one instruction per clock with a registered in_ready.
- Keeps a saturating count of illegal (unrecognised) instructions.

---
 rtl/fp_sgnj_dec_d.sv | 153 +++++++++++++++
 tb/tb_fp_sgnj_dec_d.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_sgnj_dec_d.sv
// ============================================================================
// Module   : fp_sgnj_dec_d
// Purpose  : Decode/issue stage for FSGNJ.D / FSGNJN.D / FSGNJX.D with a
//            registered output, a one-entry skid buffer and an illegal counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_sgnj_dec_d #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [63:0]      in_rs1,
   input  logic [63:0]      in_rs2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_op,
   output logic [63:0]      out_a,
   output logic [63:0]      out_b,
   output logic [4:0]       out_rd,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [6:0] c_OPCODE_OPFP  = 7'b1010011;
   localparam logic [6:0] c_FUNCT7_SGNJD = 7'b0010001;

   // Payload layout: {op[1:0], a[63:0], b[63:0], rd[4:0], illegal}
   localparam int c_PW     = 136;
   localparam int c_ILL_LO = 0;
   localparam int c_RD_LO  = 1;
   localparam int c_B_LO   = 6;
   localparam int c_A_LO   = 70;
   localparam int c_OP_LO  = 134;

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [6:0]      w_opcode;
   logic [6:0]      w_funct7;
   logic [2:0]      w_funct3;
   logic            w_legal;
   logic [1:0]      w_op;
   logic [c_PW-1:0] w_dec;
   logic            w_unused_fields;

   logic            w_in_xfer;
   logic            w_out_free;
   logic            w_cnt_sat;

   logic            w_out_valid_nxt;
   logic [c_PW-1:0] w_out_data_nxt;
   logic            w_skid_valid_nxt;
   logic [c_PW-1:0] w_skid_data_nxt;

   logic            r_out_valid;
   logic [c_PW-1:0] r_out_data;
   logic            r_skid_valid;
   logic [c_PW-1:0] r_skid_data;
   logic            r_in_ready;
   logic [CNT_W-1:0] r_cnt;

   assign w_opcode = in_instr[6:0];
   assign w_funct3 = in_instr[14:12];
   assign w_funct7 = in_instr[31:25];

   // Source-register index fields carry no meaning here; operands arrive by value.
   assign w_unused_fields = ^in_instr[24:15];

   always_comb begin
      w_legal = 1'b0;
      if ((w_opcode == c_OPCODE_OPFP) && (w_funct7 == c_FUNCT7_SGNJD)) begin
         case (w_funct3)
            3'b000,
            3'b001,
            3'b010:  w_legal = 1'b1;
            default: w_legal = 1'b0;
         endcase
      end
      w_op  = w_legal ? in_instr[13:12] : 2'b00;
      w_dec = {w_op, in_rs1, in_rs2, in_instr[11:7], ~w_legal};
   end

   assign w_in_xfer  = in_valid & r_in_ready;
   assign w_out_free = ~r_out_valid | out_ready;
   assign w_cnt_sat  = &r_cnt;

   always_comb begin
      w_out_valid_nxt  = r_out_valid;
      w_out_data_nxt   = r_out_data;
      w_skid_valid_nxt = r_skid_valid;
      w_skid_data_nxt  = r_skid_data;

      if (w_out_free) begin
         if (r_skid_valid) begin
            // Skid drains first to preserve order; in_ready was low, so no new input.
            w_out_valid_nxt  = 1'b1;
            w_out_data_nxt   = r_skid_data;
            w_skid_valid_nxt = w_in_xfer;
            if (w_in_xfer) begin
               w_skid_data_nxt = w_dec;
            end
         end else if (w_in_xfer) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_dec;
         end else begin
            w_out_valid_nxt = 1'b0;
         end
      end else if (w_in_xfer) begin
         w_skid_valid_nxt = 1'b1;
         w_skid_data_nxt  = w_dec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_in_ready   <= 1'b1;
      end else begin
         r_out_valid  <= w_out_valid_nxt;
         r_out_data   <= w_out_data_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_skid_data  <= w_skid_data_nxt;
         r_in_ready   <= ~w_skid_valid_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_in_xfer && !w_legal && !w_cnt_sat) begin
         r_cnt <= r_cnt + c_CNT_ONE;
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_op      = r_out_data[c_OP_LO +: 2];
   assign out_a       = r_out_data[c_A_LO +: 64];
   assign out_b       = r_out_data[c_B_LO +: 64];
   assign out_rd      = r_out_data[c_RD_LO +: 5];
   assign out_illegal = r_out_data[c_ILL_LO];
   assign illegal_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fp_sgnj_dec_d.sv
// ============================================================================
// Module   : tb_fp_sgnj_dec_d
// Purpose  : Directed, table-driven bench for fp_sgnj_dec_d.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_sgnj_dec_d;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [63:0] in_rs1;
   logic [63:0] in_rs2;
   logic        out_ready;

   logic        in_ready,    in_ready2;
   logic        out_valid,   out_valid2;
   logic [1:0]  out_op,      out_op2;
   logic [63:0] out_a,       out_a2;
   logic [63:0] out_b,       out_b2;
   logic [4:0]  out_rd,      out_rd2;
   logic        out_illegal, out_illegal2;
   logic [15:0] illegal_cnt;
   logic [1:0]  illegal_cnt2;

   int checks;
   int failures;
   int exp_cnt;
   int exp_cnt2;

   fp_sgnj_dec_d #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
      .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
   );

   fp_sgnj_dec_d #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready2),
      .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .out_valid(out_valid2), .out_ready(out_ready),
      .out_op(out_op2), .out_a(out_a2), .out_b(out_b2), .out_rd(out_rd2),
      .out_illegal(out_illegal2), .illegal_cnt(illegal_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [1:0]  op;
      logic [4:0]  rd;
      logic        ill;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [63:0] rs1, input logic [63:0] rs2);
      in_valid = 1'b1;
      in_instr = instr;
      in_rs1   = rs1;
      in_rs2   = rs2;
   endtask

   task automatic chk_out(input string tag, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic ill);
      chk({tag, ".valid"},   64'(out_valid),   64'd1);
      chk({tag, ".op"},      64'(out_op),      64'(op));
      chk({tag, ".a"},       out_a,            a);
      chk({tag, ".b"},       out_b,            b);
      chk({tag, ".rd"},      64'(out_rd),      64'(rd));
      chk({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_cnt  = 0;
      exp_cnt2 = 0;

      vecs[0] = '{32'h22B50553, 64'h3FF0000000000000, 64'hC000000000000000, 2'b00, 5'd10, 1'b0};
      vecs[1] = '{32'h22B51553, 64'h0123456789ABCDEF, 64'h8000000000000001, 2'b01, 5'd10, 1'b0};
      vecs[2] = '{32'h22B52553, 64'hFFFFFFFFFFFFFFFF, 64'h7FF8000000000000, 2'b10, 5'd10, 1'b0};
      vecs[3] = '{32'h22B53553, 64'h1111111111111111, 64'h2222222222222222, 2'b00, 5'd10, 1'b1};
      vecs[4] = '{32'h02B50553, 64'h3333333333333333, 64'h4444444444444444, 2'b00, 5'd10, 1'b1};
      vecs[5] = '{32'h22A52AD3, 64'hC008000000000000, 64'hC008000000000000, 2'b10, 5'd21, 1'b0};
      vecs[6] = '{32'h22B50513, 64'h5555555555555555, 64'h6666666666666666, 2'b00, 5'd10, 1'b1};
      vecs[7] = '{32'h22B54FD3, 64'h7777777777777777, 64'h8888888888888888, 2'b00, 5'd31, 1'b1};
      vecs[8] = '{32'h00000000, 64'hDEADBEEFCAFEF00D, 64'h0000000000000000, 2'b00, 5'd0,  1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_rs1    = '0;
      in_rs2    = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      chk("rst.in_ready",    64'(in_ready),    64'd1);
      chk("rst.out_valid",   64'(out_valid),   64'd0);
      chk("rst.out_op",      64'(out_op),      64'd0);
      chk("rst.out_a",       out_a,            64'd0);
      chk("rst.out_b",       out_b,            64'd0);
      chk("rst.out_rd",      64'(out_rd),      64'd0);
      chk("rst.out_illegal", 64'(out_illegal), 64'd0);
      chk("rst.illegal_cnt", 64'(illegal_cnt), 64'd0);

      // Back-to-back stream with out_ready held high: one result per clock.
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
         chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'd1);
         tick();
         if (vecs[i].ill) begin
            exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
         end
         chk_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].ill);
         chk($sformatf("vec%0d.cnt", i),  64'(illegal_cnt),  64'(exp_cnt));
         chk($sformatf("vec%0d.cnt2", i), 64'(illegal_cnt2), 64'(exp_cnt2));
      end
      in_valid = 1'b0;
      tick();
      chk("drain.out_valid", 64'(out_valid), 64'd0);
      chk("sat.cnt2",        64'(illegal_cnt2), 64'd3);

      // Stall: OUT and SKID fill, third instruction is refused until SKID frees.
      out_ready = 1'b0;
      drive(32'h22B50553, 64'hA000000000000001, 64'hB000000000000001);
      tick();
      chk("stall.first.in_ready", 64'(in_ready), 64'd1);
      drive(32'h22B51553, 64'hA000000000000002, 64'hB000000000000002);
      tick();
      chk("stall.third.in_ready", 64'(in_ready), 64'd0);
      drive(32'h22B52553, 64'hA000000000000003, 64'hB000000000000003);
      tick();
      chk("stall.hold.in_ready", 64'(in_ready), 64'd0);
      chk_out("stall.hold", 2'b00, 64'hA000000000000001, 64'hB000000000000001, 5'd10, 1'b0);
      out_ready = 1'b1;
      tick();
      chk_out("stall.second", 2'b01, 64'hA000000000000002, 64'hB000000000000002, 5'd10, 1'b0);
      chk("stall.reopen.in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk_out("stall.third", 2'b10, 64'hA000000000000003, 64'hB000000000000003, 5'd10, 1'b0);
      tick();
      chk("stall.empty.out_valid", 64'(out_valid), 64'd0);

      // Asynchronous reset while both entries are full and output is stalled.
      out_ready = 1'b0;
      drive(32'h22B53553, 64'hC000000000000001, 64'hD000000000000001);
      tick();
      drive(32'h22B51553, 64'hC000000000000002, 64'hD000000000000002);
      tick();
      in_valid = 1'b0;
      chk("mid.in_ready", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.out_valid",   64'(out_valid),   64'd0);
      chk("arst.out_a",       out_a,            64'd0);
      chk("arst.illegal_cnt", 64'(illegal_cnt), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("arst.rel.in_ready",  64'(in_ready),  64'd1);
      chk("arst.rel.out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      tick();
      chk("arst.stale1.out_valid", 64'(out_valid), 64'd0);
      tick();
      chk("arst.stale2.out_valid", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
